// File: rtl/debounce_pkg.sv
// debounce_pkg: shared state encoding and default qualification length
// for the multi-channel switch debouncer.
package debounce_pkg;

  // Per-channel debounce states; all four encodings are used.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,  // settled low
    DELAY0 = 2'b01,  // qualifying a press
    ONE    = 2'b10,  // settled high
    DELAY1 = 2'b11   // qualifying a release
  } state_t;

  // About 42 ms of stable input at 50 MHz.
  localparam int unsigned DEFAULT_LIMIT = 2_100_000;

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one debounce FSM with its own qualification timer.
// The level flips once the input has disagreed with it for LIMIT+1
// consecutive samples; rise/fall are registered one-cycle ticks.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned LIMIT = DEFAULT_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned   TW   = $clog2(LIMIT + 1);
  localparam logic [TW-1:0] TMAX = TW'(LIMIT - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          level_q, level_d;
  logic          rise_q,  rise_d;
  logic          fall_q,  fall_d;

  // Next-state, timer and tick logic; ticks default low so they last one cycle.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = DELAY0;
          timer_d = '0;
        end
      end
      DELAY0: begin
        if (!s) begin
          state_d = IDLE;
        end else if (timer_q == TMAX) begin
          state_d = ONE;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ONE: begin
        if (!s) begin
          state_d = DELAY1;
          timer_d = '0;
        end
      end
      DELAY1: begin
        if (s) begin
          state_d = ONE;
        end else if (timer_q == TMAX) begin
          state_d = IDLE;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, timer and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/debounce_multi.sv
// debounce_multi: CH independent switch debouncers.
// Define DEBOUNCE_SYNC_EN to put a 2-flop synchroniser in front of each
// channel (raw pad inputs); leave it undefined for inputs already in clk.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int          CH    = 4,
  parameter int unsigned LIMIT = DEFAULT_LIMIT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] sw,
  output logic [CH-1:0] db_level,
  output logic [CH-1:0] db_rise,
  output logic [CH-1:0] db_fall
);

  logic [CH-1:0] s;

`ifdef DEBOUNCE_SYNC_EN
  logic [CH-1:0] sync1_q, sync1_d;
  logic [CH-1:0] sync2_q, sync2_d;

  // Two-stage shift toward the FSMs.
  always_comb begin
    sync1_d = sw;
    sync2_d = sync1_q;
  end

  // Synchroniser flops, cleared by reset so a held switch requalifies.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign s = sync2_q;
`else
  assign s = sw;
`endif

  for (genvar g = 0; g < CH; g++) begin : g_ch
    debounce_channel #(
      .LIMIT (LIMIT)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .s     (s[g]),
      .level (db_level[g]),
      .rise  (db_rise[g]),
      .fall  (db_fall[g])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: vector table, latency sequences and randomized run
// against a run-length reference model, for CH=2/LIMIT=4 and CH=1/LIMIT=1.
module tb_debounce_multi;

  localparam int CH  = 2;
  localparam int LIM = 4;
`ifdef DEBOUNCE_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sw  = '0;
  logic [1:0] db_level, db_rise, db_fall;
  logic [0:0] sw1 = '0;
  logic [0:0] lvl1, rise1, fall1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  debounce_multi #(.CH(CH), .LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .sw(sw),
    .db_level(db_level), .db_rise(db_rise), .db_fall(db_fall)
  );

  debounce_multi #(.CH(1), .LIMIT(1)) dut1 (
    .clk(clk), .rst(rst), .sw(sw1),
    .db_level(lvl1), .db_rise(rise1), .db_fall(fall1)
  );

  // Reference: level flips after LIMIT+1 consecutive samples that differ
  // from it; input seen SL edges late.
  logic [1:0] m_lvl, m_rise, m_fall;
  int         m_cnt [2];
  logic [1:0] m_q [$];
  logic       m1_lvl, m1_rise, m1_fall;
  int         m1_cnt;
  logic       m1_q [$];

  task automatic model_edge(input logic r, input logic [1:0] s_in, input logic s1_in);
    logic [1:0] s;
    logic       s1;
    m_rise = '0; m_fall = '0; m1_rise = 1'b0; m1_fall = 1'b0;
    if (r) begin
      m_lvl = '0; m1_lvl = 1'b0; m_cnt[0] = 0; m_cnt[1] = 0; m1_cnt = 0;
      m_q.delete(); m1_q.delete();
      for (int k = 0; k < SL; k++) begin
        m_q.push_back(2'b00);
        m1_q.push_back(1'b0);
      end
    end else begin
      m_q.push_back(s_in);   s  = m_q.pop_front();
      m1_q.push_back(s1_in); s1 = m1_q.pop_front();
      for (int c = 0; c < CH; c++) begin
        if (s[c] != m_lvl[c]) begin
          m_cnt[c]++;
          if (m_cnt[c] == LIM + 1) begin
            m_lvl[c] = s[c];
            if (s[c]) m_rise[c] = 1'b1; else m_fall[c] = 1'b1;
            m_cnt[c] = 0;
          end
        end else begin
          m_cnt[c] = 0;
        end
      end
      if (s1 != m1_lvl) begin
        m1_cnt++;
        if (m1_cnt == 2) begin
          m1_lvl = s1;
          if (s1) m1_rise = 1'b1; else m1_fall = 1'b1;
          m1_cnt = 0;
        end
      end else begin
        m1_cnt = 0;
      end
    end
  endtask

  // Drive inputs for one edge, advance the model, sample 1 time unit later.
  task automatic step(input logic r, input logic [1:0] s, input logic s1);
    rst = r; sw = s; sw1 = s1;
    @(posedge clk);
    model_edge(r, s, s1);
    #1;
  endtask

  task automatic chk(input string name, input logic [5:0] got, input logic [5:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  typedef struct {
    logic       r;
    logic [1:0] s;
    int         n;
    logic [1:0] lvl;
    logic [1:0] rise;
    logic [1:0] fall;
  } vec_t;

  vec_t tbl [$];

  initial begin
    int hold [2];
    int hold1;
    int lat;
    bit found;
    logic [1:0] rs;
    logic       rs1;

    // Reset state and press latency (synchroniser-aware).
    step(1'b1, 2'b00, 1'b0);
    step(1'b1, 2'b00, 1'b0);
    chk("reset", {db_level, db_rise, db_fall}, 6'b0);
    chk("reset_l1", {3'b0, lvl1, rise1, fall1}, 6'b0);
    lat = 0; found = 0;
    for (int k = 1; k <= 40 && !found; k++) begin
      step(1'b0, 2'b01, 1'b1);
      if (db_rise[0]) begin found = 1; lat = k; end
    end
    chk_int("press_latency", lat, LIM + 1 + SL);
    chk("press_ch1_quiet", {4'b0, db_level[1], db_rise[1]}, 6'b0);
    step(1'b0, 2'b01, 1'b1);
    chk("rise_one_cycle", {db_level, db_rise, db_fall}, {2'b01, 2'b00, 2'b00});

    // LIMIT=1: second consecutive stable sample flips the level.
    step(1'b1, 2'b00, 1'b0);
    lat = 0; found = 0;
    for (int k = 1; k <= 40 && !found; k++) begin
      step(1'b0, 2'b00, 1'b1);
      if (rise1[0]) begin found = 1; lat = k; end
    end
    chk_int("limit1_latency", lat, 2 + SL);

`ifndef DEBOUNCE_SYNC_EN
    tbl.push_back('{1'b1, 2'b00, 2, 2'b00, 2'b00, 2'b00});
    // press ch0
    tbl.push_back('{1'b0, 2'b01, 4, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b01, 1, 2'b01, 2'b01, 2'b00});
    tbl.push_back('{1'b0, 2'b01, 3, 2'b01, 2'b00, 2'b00});
    // 2-edge release glitch
    tbl.push_back('{1'b0, 2'b00, 2, 2'b01, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b01, 3, 2'b01, 2'b00, 2'b00});
    // full release
    tbl.push_back('{1'b0, 2'b00, 4, 2'b01, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b00, 1, 2'b00, 2'b00, 2'b01});
    tbl.push_back('{1'b0, 2'b00, 2, 2'b00, 2'b00, 2'b00});
    // press glitches of 3 and LIMIT edges
    tbl.push_back('{1'b0, 2'b01, 3, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b00, 4, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b01, 4, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b00, 3, 2'b00, 2'b00, 2'b00});
    // both channels together, then ch1 released alone
    tbl.push_back('{1'b0, 2'b11, 4, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b11, 1, 2'b11, 2'b11, 2'b00});
    tbl.push_back('{1'b0, 2'b11, 2, 2'b11, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b01, 4, 2'b11, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b01, 1, 2'b01, 2'b00, 2'b10});
    tbl.push_back('{1'b0, 2'b01, 2, 2'b01, 2'b00, 2'b00});
    // back to low, then reset at edge 3 of a press
    tbl.push_back('{1'b0, 2'b00, 4, 2'b01, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b00, 1, 2'b00, 2'b00, 2'b01});
    tbl.push_back('{1'b0, 2'b00, 1, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b01, 2, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{1'b1, 2'b01, 1, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b01, 4, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b01, 1, 2'b01, 2'b01, 2'b00});
    tbl.push_back('{1'b0, 2'b01, 1, 2'b01, 2'b00, 2'b00});
    // reset while settled high, switch still held
    tbl.push_back('{1'b1, 2'b01, 1, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b01, 4, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b01, 1, 2'b01, 2'b01, 2'b00});
    tbl.push_back('{1'b0, 2'b01, 1, 2'b01, 2'b00, 2'b00});
    foreach (tbl[i]) begin
      for (int e = 0; e < tbl[i].n; e++) begin
        step(tbl[i].r, tbl[i].s, 1'b0);
        chk($sformatf("tbl[%0d].%0d", i, e), {db_level, db_rise, db_fall},
            {tbl[i].lvl, tbl[i].rise, tbl[i].fall});
      end
    end
`endif

    // Randomized holds with occasional reset, checked every cycle.
    step(1'b1, 2'b00, 1'b0);
    rs = '0; rs1 = 1'b0;
    hold[0] = 0; hold[1] = 0; hold1 = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int c = 0; c < CH; c++) begin
        if (hold[c] == 0) begin
          rs[c]   = 1'($urandom_range(0, 1));
          hold[c] = int'($urandom_range(1, 8));
        end
        hold[c]--;
      end
      if (hold1 == 0) begin
        rs1   = 1'($urandom_range(0, 1));
        hold1 = int'($urandom_range(1, 3));
      end
      hold1--;
      step(($urandom_range(0, 299) == 0), rs, rs1);
      chk("rand", {db_level, db_rise, db_fall}, {m_lvl, m_rise, m_fall});
      chk("rand_l1", {3'b0, lvl1, rise1, fall1}, {3'b0, m1_lvl, m1_rise, m1_fall});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
